// File: rtl/simple_mem_pkg.sv
// Shared types and constants for the SIMPLE pipeline memory stage.
package simple_mem_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam logic [15:0] MMIO_LED_ADDR = 16'hFFFF;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Source of the write-back data word.
  typedef enum logic [1:0] {
    WB_ALU,
    WB_RAM,
    WB_ZERO,
    WB_LED
  } wb_src_t;

  // True when the word address lies outside a RAM of 2**aw words.
  function automatic logic out_of_range(input logic [15:0] addr, input int unsigned aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/p4_mem_stage_if.sv
// Registered memory request bus from the execute stage to the memory stage.
interface p4_mem_stage_if;
  import simple_mem_pkg::*;

  logic [DATA_W-1:0] Address;
  logic [DATA_W-1:0] storeData;
  logic              readEnable;
  logic              writeEnable;

  modport master (
    output Address,
    output storeData,
    output readEnable,
    output writeEnable
  );

  modport slave (
    input Address,
    input storeData,
    input readEnable,
    input writeEnable
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, 1-cycle read; a write returns the new word.
module dmem_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write-first port: the stored word appears on rdata on the same edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/p4_mem_stage.sv
// Memory stage: owns the data RAM, inserts load wait states, drives write-back.
// Optional feature: define MMIO_LED_EN to add the io_led register at 16'hFFFF.
module p4_mem_stage
  import simple_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     aluOutput,
  input  logic                  writeRegp3,
  input  logic [REG_ADDR_W-1:0] regAddressp3,
  p4_mem_stage_if.slave         bus,
  output logic [DATA_W-1:0]     wbData,
  output logic                  wbWrite,
  output logic [REG_ADDR_W-1:0] wbRegAddress,
  output logic                  stall
`ifdef MMIO_LED_EN
  ,
  output logic [DATA_W-1:0]     io_led
`endif
);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [DATA_W-1:0]     lat_addr;
  logic                  lat_wr;
  logic [REG_ADDR_W-1:0] lat_ra;
  wb_src_t               wb_src;
  logic [DATA_W-1:0]     alu_q;

  logic [DATA_W-1:0]     req_addr;
  logic                  req_oor;
  logic                  req_mmio;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;
  wb_src_t               load_src;
  logic                  led_val_unused;

  // Request decode: BUSY replays the latched load address.
  always_comb begin
    req_addr = (state == BUSY) ? lat_addr : bus.Address;
`ifdef MMIO_LED_EN
    req_mmio = (req_addr == MMIO_LED_ADDR);
`else
    req_mmio = 1'b0;
`endif
    req_oor  = out_of_range(req_addr, ADDR_W);
    ram_we   = (state == IDLE) && bus.writeEnable && !req_oor && !req_mmio;
    if (req_mmio)     load_src = WB_LED;
    else if (req_oor) load_src = WB_ZERO;
    else              load_src = WB_RAM;
  end

  dmem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (req_addr[ADDR_W-1:0]),
    .wdata(bus.storeData),
    .rdata(ram_rdata)
  );

`ifdef MMIO_LED_EN
  // LED register: written by an IDLE store to the MMIO address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_led <= '0;
    end else if (state == IDLE && bus.writeEnable && req_mmio) begin
      io_led <= bus.storeData;
    end
  end
  assign led_val_unused = 1'b0;
`else
  assign led_val_unused = 1'b0;
`endif

  // Write-back data select; RAM data comes straight from the RAM output register.
  always_comb begin
    unique case (wb_src)
      WB_RAM:  wbData = ram_rdata;
      WB_ZERO: wbData = '0;
`ifdef MMIO_LED_EN
      WB_LED:  wbData = io_led;
`else
      WB_LED:  wbData = {DATA_W{led_val_unused}};
`endif
      default: wbData = alu_q;
    endcase
  end

  // Control FSM: accepts requests in IDLE, counts load wait states in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_addr     <= '0;
      lat_wr       <= 1'b0;
      lat_ra       <= '0;
      wb_src       <= WB_ALU;
      alu_q        <= '0;
      wbWrite      <= 1'b0;
      wbRegAddress <= '0;
      stall        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.readEnable && !bus.writeEnable && WAIT_STATES != 0) begin
            // Freeze the visible word so wbData holds steady while stalled.
            state    <= BUSY;
            wait_cnt <= 4'(WAIT_STATES);
            lat_addr <= bus.Address;
            lat_wr   <= writeRegp3;
            lat_ra   <= regAddressp3;
            alu_q    <= wbData;
            wb_src   <= WB_ALU;
            wbWrite  <= 1'b0;
            stall    <= 1'b1;
          end else begin
            wbWrite      <= writeRegp3;
            wbRegAddress <= regAddressp3;
            if (bus.readEnable && !bus.writeEnable) begin
              wb_src <= load_src;
            end else begin
              wb_src <= WB_ALU;
              alu_q  <= aluOutput;
            end
          end
        end
        BUSY: begin
          if (wait_cnt == 4'd1) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            stall        <= 1'b0;
            wbWrite      <= lat_wr;
            wbRegAddress <= lat_ra;
            wb_src       <= load_src;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
